// File: rtl/meas_frame_scheduler_if.sv
// Control, demod and UART byte-port signals of the measurement frame scheduler.
// The master modport is the scheduler's view; slave is the surrounding system.
interface meas_frame_scheduler_if;
    logic        Enable;
    logic [1:0]  ChMask;
    logic        Done;
    logic        Busy;
    logic        TimeoutErr;
    logic        DemodEnCh1;
    logic        DemodEnCh2;
    logic        DemodReadyCh1;
    logic        DemodReadyCh2;
    logic [31:0] DemodResultCh1;
    logic [31:0] DemodResultCh2;
    logic        UARTAvl;
    logic [7:0]  UARTSend;
    logic        UARTDatLock;

    modport master (
        input  Enable, ChMask, DemodReadyCh1, DemodReadyCh2,
               DemodResultCh1, DemodResultCh2, UARTAvl,
        output Done, Busy, TimeoutErr, DemodEnCh1, DemodEnCh2,
               UARTSend, UARTDatLock
    );

    modport slave (
        output Enable, ChMask, DemodReadyCh1, DemodReadyCh2,
               DemodResultCh1, DemodResultCh2, UARTAvl,
        input  Done, Busy, TimeoutErr, DemodEnCh1, DemodEnCh2,
               UARTSend, UARTDatLock
    );
endinterface

// File: rtl/meas_frame_scheduler.sv
// Runs NUM_MEAS demodulations round-robin over the enabled channels and
// streams each 32-bit result, framed by a header and checksum, over the UART byte port.
module meas_frame_scheduler #(
    parameter int unsigned NUM_MEAS = 8,
    parameter logic [7:0]  HEADER   = 8'hAA,
    parameter int unsigned TIMEOUT  = 65535
) (
    input logic                    Clk,
    input logic                    Rst,
    meas_frame_scheduler_if.master bus
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT - 1);
    localparam logic [7:0]    LAST_MEAS = 8'(NUM_MEAS - 1);

    typedef enum logic [2:0] {
        IDLE, HDR, DEMOD, WAIT_RDY, SHIFT, SEND, WAIT_BUSY, DONE
    } state_t;

    state_t      state, stateNext, retState;
    logic [1:0]  mask;
    logic        curCh;
    logic [7:0]  measCnt;
    logic [2:0]  byteCnt;
    logic [TW-1:0] timeoutCnt;
    logic [31:0] result;
    logic [7:0]  byteReg;
    logic [7:0]  csum;
    logic [7:0]  uartSend;
    logic        datLock;
    logic        demodEn1;
    logic        demodEn2;
    logic        timeoutErr;

    logic        readyCur;
    logic [31:0] resultCur;
    logic        abort;
    logic        timedOut;
    logic        lastMeas;

    assign readyCur  = curCh ? bus.DemodReadyCh2  : bus.DemodReadyCh1;
    assign resultCur = curCh ? bus.DemodResultCh2 : bus.DemodResultCh1;
    assign abort     = !bus.Enable && (state != IDLE);
    assign timedOut  = (timeoutCnt == TMAX);
    assign lastMeas  = (measCnt == LAST_MEAS);

    assign bus.Done        = (state == DONE);
    assign bus.Busy        = (state != IDLE) && (state != DONE);
    assign bus.TimeoutErr  = timeoutErr;
    assign bus.DemodEnCh1  = demodEn1;
    assign bus.DemodEnCh2  = demodEn2;
    assign bus.UARTSend    = uartSend;
    assign bus.UARTDatLock = datLock;

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:      if (bus.Enable) stateNext = (bus.ChMask != 2'b00) ? HDR : DONE;
            HDR:       stateNext = SEND;
            DEMOD:     stateNext = WAIT_RDY;
            WAIT_RDY:  if (readyCur || timedOut) stateNext = SHIFT;
            SHIFT:     stateNext = (byteCnt != 3'd4 || lastMeas) ? SEND : DEMOD;
            SEND:      if (bus.UARTAvl) stateNext = WAIT_BUSY;
            WAIT_BUSY: if (!bus.UARTAvl) stateNext = retState;
            DONE:      stateNext = DONE;
            default:   stateNext = IDLE;
        endcase
        // Enable low wins over everything except reset, including the DONE hold.
        if (abort) stateNext = IDLE;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            retState   <= IDLE;
            mask       <= 2'b00;
            curCh      <= 1'b0;
            measCnt    <= 8'd0;
            byteCnt    <= 3'd0;
            timeoutCnt <= '0;
            result     <= 32'd0;
            byteReg    <= 8'd0;
            csum       <= 8'd0;
            uartSend   <= 8'd0;
            datLock    <= 1'b0;
            demodEn1   <= 1'b0;
            demodEn2   <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            datLock <= 1'b0;
            if (abort) begin
                demodEn1   <= 1'b0;
                demodEn2   <= 1'b0;
                timeoutErr <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.Enable) begin
                        mask       <= bus.ChMask;
                        measCnt    <= 8'd0;
                        csum       <= 8'd0;
                        timeoutErr <= 1'b0;
                        curCh      <= !bus.ChMask[0];
                    end
                    HDR: begin
                        byteReg  <= HEADER;
                        retState <= DEMOD;
                    end
                    DEMOD: begin
                        demodEn1   <= !curCh;
                        demodEn2   <= curCh;
                        timeoutCnt <= '0;
                    end
                    WAIT_RDY: begin
                        // A Ready arriving on the expiry cycle still counts as a real result.
                        if (readyCur || timedOut) begin
                            result   <= readyCur ? resultCur : 32'hFFFF_FFFF;
                            demodEn1 <= 1'b0;
                            demodEn2 <= 1'b0;
                            byteCnt  <= 3'd0;
                            if (!readyCur) timeoutErr <= 1'b1;
                        end else begin
                            timeoutCnt <= timeoutCnt + 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (byteCnt != 3'd4) begin
                            byteReg  <= result[31:24];
                            result   <= {result[23:0], 8'h00};
                            byteCnt  <= byteCnt + 3'd1;
                            retState <= SHIFT;
                        end else begin
                            measCnt <= measCnt + 8'd1;
                            if (lastMeas) begin
                                byteReg  <= csum;
                                retState <= DONE;
                            end else if (mask == 2'b11) begin
                                curCh <= !curCh;
                            end
                        end
                    end
                    SEND: if (bus.UARTAvl) begin
                        uartSend <= byteReg;
                        datLock  <= 1'b1;
                        // Only payload bytes return to SHIFT; header and checksum are excluded.
                        if (retState == SHIFT) csum <= csum + byteReg;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_meas_frame_scheduler.sv
// Bench for meas_frame_scheduler: UART and demod responders plus a frame-level
// reference model that predicts the byte stream from mask, results and timeouts.
module tb_meas_frame_scheduler;
    localparam int NM = 3;
    localparam int TO = 16;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    meas_frame_scheduler_if bus();

    meas_frame_scheduler #(.NUM_MEAS(NM), .HEADER(8'hAA), .TIMEOUT(TO)) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    int nChecks = 0;
    int nPassed = 0;

    logic [7:0]  got[$];
    logic [7:0]  expBytes[$];
    bit          expTerr;
    int          ep1[$];
    int          en1Edges, en2Edges;
    bit          stall = 0;
    int          ackDly = 0;
    bit          resp1 = 1, resp2 = 1, noise = 0;
    logic [31:0] res1 = 0, res2 = 0;

    // UART transmitter: goes busy on each strobe for ackDly (or random) cycles.
    initial begin
        int ack;
        ack = 0;
        bus.UARTAvl = 1'b1;
        forever begin
            @(negedge Clk);
            if (bus.UARTDatLock === 1'b1) begin
                got.push_back(bus.UARTSend);
                ack = (ackDly != 0) ? ackDly : $urandom_range(1, 4);
                bus.UARTAvl = 1'b0;
            end else if (stall) begin
                bus.UARTAvl = 1'b0;
            end else if (ack > 0) begin
                ack--;
                bus.UARTAvl = (ack == 0);
            end else begin
                bus.UARTAvl = 1'b1;
            end
        end
    end

    // Demod cores: one Ready pulse per request after a random delay; optional stray Ready.
    initial begin
        bit pend1, pend2;
        int dly1, dly2;
        pend1 = 0; pend2 = 0; dly1 = 0; dly2 = 0;
        bus.DemodReadyCh1 = 0; bus.DemodReadyCh2 = 0;
        bus.DemodResultCh1 = 0; bus.DemodResultCh2 = 0;
        forever begin
            @(negedge Clk);
            bus.DemodReadyCh1 = 0;
            bus.DemodReadyCh2 = 0;
            if (bus.DemodEnCh1 === 1'b1) begin
                if (!pend1 && resp1) begin
                    if (dly1 == 0) begin
                        bus.DemodReadyCh1 = 1; bus.DemodResultCh1 = res1; pend1 = 1;
                    end else dly1--;
                end
            end else begin
                pend1 = 0; dly1 = $urandom_range(0, 4);
                if (noise && $urandom_range(0, 3) == 0) begin
                    bus.DemodReadyCh1 = 1; bus.DemodResultCh1 = $urandom;
                end
            end
            if (bus.DemodEnCh2 === 1'b1) begin
                if (!pend2 && resp2) begin
                    if (dly2 == 0) begin
                        bus.DemodReadyCh2 = 1; bus.DemodResultCh2 = res2; pend2 = 1;
                    end else dly2--;
                end
            end else begin
                pend2 = 0; dly2 = $urandom_range(0, 4);
                if (noise && $urandom_range(0, 3) == 0) begin
                    bus.DemodReadyCh2 = 1; bus.DemodResultCh2 = $urandom;
                end
            end
        end
    end

    // Request edge counts and ch1 request-high episode lengths.
    initial begin
        bit p1, p2;
        int run1;
        p1 = 0; p2 = 0; run1 = 0;
        forever begin
            @(negedge Clk);
            if (bus.DemodEnCh1 === 1'b1 && !p1) en1Edges++;
            if (bus.DemodEnCh2 === 1'b1 && !p2) en2Edges++;
            p1 = (bus.DemodEnCh1 === 1'b1);
            p2 = (bus.DemodEnCh2 === 1'b1);
            if (p1) run1++;
            else if (run1 > 0) begin ep1.push_back(run1); run1 = 0; end
        end
    end

    task automatic model_frame(input logic [1:0] m, input logic [31:0] r1, input logic [31:0] r2,
                               input bit ok1, input bit ok2);
        logic [31:0] v;
        logic [7:0]  sum;
        int ch;
        expBytes.delete();
        expTerr = 0;
        sum = 8'h00;
        if (m == 2'b00) return;
        expBytes.push_back(8'hAA);
        ch = m[0] ? 1 : 2;
        for (int i = 0; i < NM; i++) begin
            if (ch == 1) v = ok1 ? r1 : 32'hFFFF_FFFF;
            else         v = ok2 ? r2 : 32'hFFFF_FFFF;
            if ((ch == 1 && !ok1) || (ch == 2 && !ok2)) expTerr = 1;
            for (int b = 3; b >= 0; b--) begin
                expBytes.push_back(v[8*b +: 8]);
                sum = sum + v[8*b +: 8];
            end
            if (m == 2'b11) ch = 3 - ch;
        end
        expBytes.push_back(sum);
    endtask

    task automatic start_frame(input logic [1:0] m, input logic [31:0] r1, input logic [31:0] r2,
                               input bit ok1, input bit ok2);
        res1 = r1; res2 = r2; resp1 = ok1; resp2 = ok2;
        model_frame(m, r1, r2, ok1, ok2);
        @(negedge Clk);
        got.delete(); ep1.delete(); en1Edges = 0; en2Edges = 0;
        bus.ChMask = m;
        bus.Enable = 1'b1;
    endtask

    task automatic wait_done();
        int c = 0;
        while (bus.Done !== 1'b1 && c < 20000) begin @(negedge Clk); c++; end
    endtask

    task automatic end_frame();
        @(negedge Clk);
        bus.Enable = 1'b0;
        bus.ChMask = 2'b00;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_reset();
        Rst = 1'b1; bus.Enable = 1'b0; bus.ChMask = 2'b00;
        repeat (3) @(negedge Clk);
        nChecks++;
        if ({bus.Done, bus.Busy, bus.TimeoutErr, bus.DemodEnCh1, bus.DemodEnCh2, bus.UARTDatLock} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000",
                     {bus.Done, bus.Busy, bus.TimeoutErr, bus.DemodEnCh1, bus.DemodEnCh2, bus.UARTDatLock});
        else nPassed++;
        nChecks++;
        if (bus.UARTSend !== 8'h00) $display("FAIL reset_send: got %02h want 00", bus.UARTSend);
        else nPassed++;
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_two_channel();
        ackDly = 3; noise = 0;
        start_frame(2'b11, 32'h11223344, 32'hA0B0C0D0, 1, 1);
        wait_done();
        nChecks++;
        if ({bus.Done, bus.Busy} !== 2'b10) $display("FAIL two_ch done/busy: got %b want 10", {bus.Done, bus.Busy});
        else nPassed++;
        nChecks++;
        if (got.size() != expBytes.size()) $display("FAIL two_ch len: got %0d want %0d", got.size(), expBytes.size());
        else nPassed++;
        for (int i = 0; i < expBytes.size() && i < got.size(); i++) begin
            nChecks++;
            if (got[i] !== expBytes[i]) $display("FAIL two_ch byte%0d: got %02h want %02h", i, got[i], expBytes[i]);
            else nPassed++;
        end
        nChecks++;
        if (bus.TimeoutErr !== 1'b0) $display("FAIL two_ch terr: got %b want 0", bus.TimeoutErr);
        else nPassed++;
        end_frame();
        nChecks++;
        if (bus.Done !== 1'b0) $display("FAIL two_ch done_clear: got %b want 0", bus.Done);
        else nPassed++;
        ackDly = 0;
    endtask

    task automatic test_single_channel();
        noise = 1;
        start_frame(2'b10, $urandom, 32'h0000_0001, 1, 1);
        wait_done();
        nChecks++;
        if (got.size() != expBytes.size()) $display("FAIL ch2_only len: got %0d want %0d", got.size(), expBytes.size());
        else nPassed++;
        for (int i = 0; i < expBytes.size() && i < got.size(); i++) begin
            nChecks++;
            if (got[i] !== expBytes[i]) $display("FAIL ch2_only byte%0d: got %02h want %02h", i, got[i], expBytes[i]);
            else nPassed++;
        end
        nChecks++;
        if (en1Edges != 0 || en2Edges != NM)
            $display("FAIL ch2_only edges: got ch1=%0d ch2=%0d want ch1=0 ch2=%0d", en1Edges, en2Edges, NM);
        else nPassed++;
        end_frame();
        noise = 0;
    endtask

    task automatic test_timeout();
        start_frame(2'b01, $urandom, $urandom, 0, 1);
        wait_done();
        nChecks++;
        if (bus.TimeoutErr !== 1'b1) $display("FAIL timeout terr: got %b want 1", bus.TimeoutErr);
        else nPassed++;
        nChecks++;
        if (got.size() != expBytes.size()) $display("FAIL timeout len: got %0d want %0d", got.size(), expBytes.size());
        else nPassed++;
        for (int i = 0; i < expBytes.size() && i < got.size(); i++) begin
            nChecks++;
            if (got[i] !== expBytes[i]) $display("FAIL timeout byte%0d: got %02h want %02h", i, got[i], expBytes[i]);
            else nPassed++;
        end
        nChecks++;
        if (ep1.size() != NM) $display("FAIL timeout episodes: got %0d want %0d", ep1.size(), NM);
        else nPassed++;
        foreach (ep1[i]) begin
            nChecks++;
            if (ep1[i] != TO) $display("FAIL timeout en_len%0d: got %0d want %0d", i, ep1[i], TO);
            else nPassed++;
        end
        end_frame();
        nChecks++;
        if (bus.TimeoutErr !== 1'b0) $display("FAIL timeout terr_clear: got %b want 0", bus.TimeoutErr);
        else nPassed++;
    endtask

    task automatic test_uart_stall();
        int c = 0;
        int n;
        start_frame(2'b01, $urandom, $urandom, 1, 1);
        while (got.size() < 1 && c < 200) begin @(negedge Clk); c++; end
        stall = 1;
        n = got.size();
        repeat (100) @(negedge Clk);
        nChecks++;
        if (got.size() != 1 || n != 1) $display("FAIL stall strobes: got %0d bytes want 1", got.size());
        else nPassed++;
        stall = 0;
        wait_done();
        nChecks++;
        if (got.size() != expBytes.size()) $display("FAIL stall len: got %0d want %0d", got.size(), expBytes.size());
        else nPassed++;
        for (int i = 0; i < expBytes.size() && i < got.size(); i++) begin
            nChecks++;
            if (got[i] !== expBytes[i]) $display("FAIL stall byte%0d: got %02h want %02h", i, got[i], expBytes[i]);
            else nPassed++;
        end
        end_frame();
    endtask

    task automatic test_abort();
        int c = 0;
        start_frame(2'b11, 32'h11223344, 32'h55667788, 1, 1);
        while (got.size() < 2 && c < 500) begin @(negedge Clk); c++; end
        stall = 1;
        repeat (5) @(negedge Clk);
        bus.Enable = 1'b0;
        @(negedge Clk);
        nChecks++;
        if ({bus.Done, bus.Busy, bus.TimeoutErr, bus.DemodEnCh1, bus.DemodEnCh2, bus.UARTDatLock} !== 6'b0)
            $display("FAIL abort_outs: got %b want 000000",
                     {bus.Done, bus.Busy, bus.TimeoutErr, bus.DemodEnCh1, bus.DemodEnCh2, bus.UARTDatLock});
        else nPassed++;
        nChecks++;
        if (got.size() != 2) $display("FAIL abort_bytes: got %0d want 2", got.size());
        else nPassed++;
        stall = 0;
        repeat (3) @(negedge Clk);
        start_frame(2'b11, 32'h11223344, 32'h55667788, 1, 1);
        wait_done();
        nChecks++;
        if (got.size() != expBytes.size()) $display("FAIL restart len: got %0d want %0d", got.size(), expBytes.size());
        else nPassed++;
        for (int i = 0; i < expBytes.size() && i < got.size(); i++) begin
            nChecks++;
            if (got[i] !== expBytes[i]) $display("FAIL restart byte%0d: got %02h want %02h", i, got[i], expBytes[i]);
            else nPassed++;
        end
        end_frame();
    endtask

    task automatic test_rst_mid();
        int c = 0;
        start_frame(2'b01, $urandom, $urandom, 0, 0);
        while (bus.DemodEnCh1 !== 1'b1 && c < 200) begin @(negedge Clk); c++; end
        nChecks++;
        if (bus.DemodEnCh1 !== 1'b1) $display("FAIL rst_mid reach_wait: got %b want 1", bus.DemodEnCh1);
        else nPassed++;
        Rst = 1'b1; bus.Enable = 1'b0; bus.ChMask = 2'b00;
        @(negedge Clk);
        nChecks++;
        if ({bus.Done, bus.Busy, bus.TimeoutErr, bus.DemodEnCh1, bus.DemodEnCh2, bus.UARTDatLock} !== 6'b0
            || bus.UARTSend !== 8'h00)
            $display("FAIL rst_mid outs: got %b/%02h want 000000/00",
                     {bus.Done, bus.Busy, bus.TimeoutErr, bus.DemodEnCh1, bus.DemodEnCh2, bus.UARTDatLock}, bus.UARTSend);
        else nPassed++;
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        nChecks++;
        if ({bus.Done, bus.Busy} !== 2'b00) $display("FAIL rst_mid idle: got %b want 00", {bus.Done, bus.Busy});
        else nPassed++;
    endtask

    task automatic test_empty_mask();
        start_frame(2'b00, 0, 0, 1, 1);
        repeat (5) @(negedge Clk);
        nChecks++;
        if ({bus.Done, bus.Busy} !== 2'b10 || got.size() != 0)
            $display("FAIL empty_mask: got done/busy %b bytes %0d want 10 bytes 0", {bus.Done, bus.Busy}, got.size());
        else nPassed++;
        end_frame();
    endtask

    task automatic test_random_frames();
        for (int k = 0; k < 6; k++) begin
            logic [1:0] m;
            bit ok1, ok2;
            m   = 2'($urandom_range(1, 3));
            ok1 = ($urandom_range(0, 3) != 0);
            ok2 = ($urandom_range(0, 3) != 0);
            noise = 1;
            start_frame(m, $urandom, $urandom, ok1, ok2);
            wait_done();
            nChecks++;
            if (got.size() != expBytes.size()) $display("FAIL rand%0d len: got %0d want %0d", k, got.size(), expBytes.size());
            else nPassed++;
            for (int i = 0; i < expBytes.size() && i < got.size(); i++) begin
                nChecks++;
                if (got[i] !== expBytes[i]) $display("FAIL rand%0d byte%0d: got %02h want %02h", k, i, got[i], expBytes[i]);
                else nPassed++;
            end
            nChecks++;
            if (bus.TimeoutErr !== expTerr) $display("FAIL rand%0d terr: got %b want %b", k, bus.TimeoutErr, expTerr);
            else nPassed++;
            end_frame();
        end
        noise = 0;
    endtask

    initial begin
        bus.Enable = 1'b0;
        bus.ChMask = 2'b00;
        test_reset();
        test_two_channel();
        test_single_channel();
        test_timeout();
        test_uart_stall();
        test_abort();
        test_rst_mid();
        test_empty_mask();
        test_random_frames();
        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end
endmodule
